// File: rtl/regfile_scoreboard_if.sv
// Port bundle for the scoreboarded register file: one write port, one reserve
// port, two bypassed read ports and an unbypassed debug read port.
interface regfile_scoreboard_if #(
    parameter int SIZE = 8,
    parameter int AW   = 3
);
    logic            Write;
    logic [AW-1:0]   DAddress;
    logic [SIZE-1:0] DataInRegg;
    logic            Rsv;
    logic [AW-1:0]   RAddress;
    logic [AW-1:0]   AAddress;
    logic [AW-1:0]   BAddress;
    logic [AW-1:0]   DbgAddress;
    logic [SIZE-1:0] dataA;
    logic [SIZE-1:0] dataB;
    logic            busyA;
    logic            busyB;
    logic            anyBusy;
    logic [SIZE-1:0] DbgData;

    modport master (
        output Write, DAddress, DataInRegg, Rsv, RAddress, AAddress, BAddress, DbgAddress,
        input  dataA, dataB, busyA, busyB, anyBusy, DbgData
    );

    modport slave (
        input  Write, DAddress, DataInRegg, Rsv, RAddress, AAddress, BAddress, DbgAddress,
        output dataA, dataB, busyA, busyB, anyBusy, DbgData
    );
endinterface

// File: rtl/regfile_scoreboard.sv
// Register file with per-register pending (scoreboard) bits, write-through
// bypass on the A/B read ports and an optional hardwired-zero register 0.
module regfile_scoreboard #(
    parameter int SIZE    = 8,
    parameter int NREG    = 8,
    parameter int AW      = 3,
    parameter int ZERO_R0 = 0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    regfile_scoreboard_if.slave  rf
);
    logic [NREG-1:0][SIZE-1:0] regs;
    logic [NREG-1:0]           pend;
    logic [NREG-1:0]           wen;
    logic [NREG-1:0]           rsv;

    // Decoded enables already exclude register 0 in the hardwired-zero build,
    // so storage, scoreboard and bypass all inherit that rule from here.
    always_comb begin
        wen = '0;
        rsv = '0;
        for (int i = 0; i < NREG; i++) begin
            wen[i] = rf.Write && (rf.DAddress == AW'(i)) && !((ZERO_R0 != 0) && (i == 0));
            rsv[i] = rf.Rsv   && (rf.RAddress == AW'(i)) && !((ZERO_R0 != 0) && (i == 0));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            regs <= '0;
            pend <= '0;
        end else begin
            for (int i = 0; i < NREG; i++) begin
                if (wen[i])
                    regs[i] <= rf.DataInRegg;
                // Reserve beats a same-cycle write: the new owner is still outstanding.
                if (rsv[i])
                    pend[i] <= 1'b1;
                else if (wen[i])
                    pend[i] <= 1'b0;
            end
        end
    end

    assign rf.dataA   = wen[rf.AAddress] ? rf.DataInRegg : regs[rf.AAddress];
    assign rf.dataB   = wen[rf.BAddress] ? rf.DataInRegg : regs[rf.BAddress];
    assign rf.DbgData = regs[rf.DbgAddress];
    assign rf.busyA   = pend[rf.AAddress];
    assign rf.busyB   = pend[rf.BAddress];
    assign rf.anyBusy = |pend;
endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed bench: a normal build and a hardwired-zero build share clock and reset.
module tb_regfile_scoreboard;
    logic clk = 1'b0;
    logic rst_n;
    int   n_chk  = 0;
    int   n_fail = 0;

    always #10 clk = ~clk;

    regfile_scoreboard_if #(.SIZE(8), .AW(3)) r ();
    regfile_scoreboard_if #(.SIZE(8), .AW(3)) z ();

    regfile_scoreboard #(.SIZE(8), .NREG(8), .AW(3), .ZERO_R0(0)) u_dut (
        .clk(clk), .rst_n(rst_n), .rf(r.slave)
    );
    regfile_scoreboard #(.SIZE(8), .NREG(8), .AW(3), .ZERO_R0(1)) u_dut_z (
        .clk(clk), .rst_n(rst_n), .rf(z.slave)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        r.Write = 1'b1; r.DAddress = 3'd1; r.DataInRegg = 8'h5A;
        r.Rsv = 1'b1;   r.RAddress = 3'd1;
        r.AAddress = 3'd1; r.BAddress = 3'd0; r.DbgAddress = 3'd1;
        z.Write = 1'b0; z.DAddress = '0; z.DataInRegg = '0; z.Rsv = 1'b0; z.RAddress = '0;
        z.AAddress = '0; z.BAddress = '0; z.DbgAddress = '0;
        #1;
        chk("rst_bypass_a", r.dataA, 8'h5A);
        chk("rst_dbg_nobyp", r.DbgData, 8'h00);
        chk("rst_busy_any", r.anyBusy, 1'b0);
        tick();
        // Write/Rsv seen during reset must not land
        r.Write = 1'b0; r.Rsv = 1'b0;
        #1;
        chk("rst_ignored_data", r.dataA, 8'h00);
        chk("rst_ignored_busy", r.busyA, 1'b0);
        tick();
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 8; i++) begin
            r.AAddress = 3'(i); r.BAddress = 3'(7 - i); r.DbgAddress = 3'(i);
            #1;
            chk($sformatf("reset_a%0d", i), r.dataA, 8'h00);
            chk($sformatf("reset_b%0d", 7 - i), r.dataB, 8'h00);
            chk($sformatf("reset_dbg%0d", i), r.DbgData, 8'h00);
            chk($sformatf("reset_busya%0d", i), r.busyA, 1'b0);
            chk($sformatf("reset_busyb%0d", 7 - i), r.busyB, 1'b0);
        end
        chk("reset_any", r.anyBusy, 1'b0);

        tick();
        r.Write = 1'b1; r.DAddress = 3'd5; r.DataInRegg = 8'hA5;
        r.AAddress = 3'd5; r.BAddress = 3'd5; r.DbgAddress = 3'd5;
        #1;
        chk("byp_a5", r.dataA, 8'hA5);
        chk("byp_b5", r.dataB, 8'hA5);
        chk("dbg5_before", r.DbgData, 8'h00);
        tick();
        r.Write = 1'b0;
        #1;
        chk("dbg5_after", r.DbgData, 8'hA5);
        chk("a5_after", r.dataA, 8'hA5);

        r.Rsv = 1'b1; r.RAddress = 3'd3; r.AAddress = 3'd3;
        #1;
        chk("busy3_not_comb", r.busyA, 1'b0);
        tick();
        r.Rsv = 1'b0;
        #1;
        chk("busy3_set", r.busyA, 1'b1);
        chk("any_set", r.anyBusy, 1'b1);
        r.Write = 1'b1; r.DAddress = 3'd3; r.DataInRegg = 8'h3C;
        #1;
        chk("busy3_hold_comb", r.busyA, 1'b1);
        chk("byp_a3", r.dataA, 8'h3C);
        tick();
        r.Write = 1'b0;
        #1;
        chk("busy3_clr", r.busyA, 1'b0);
        chk("any_clr", r.anyBusy, 1'b0);
        chk("a3_data", r.dataA, 8'h3C);

        r.Rsv = 1'b1; r.RAddress = 3'd2;
        r.Write = 1'b1; r.DAddress = 3'd2; r.DataInRegg = 8'h77;
        tick();
        r.Rsv = 1'b0; r.Write = 1'b0;
        r.AAddress = 3'd2; r.DbgAddress = 3'd2;
        #1;
        chk("same_addr_data", r.DbgData, 8'h77);
        chk("same_addr_busy", r.busyA, 1'b1);

        r.Rsv = 1'b1; r.RAddress = 3'd6;
        r.Write = 1'b1; r.DAddress = 3'd2; r.DataInRegg = 8'h22;
        r.BAddress = 3'd6;
        tick();
        r.Rsv = 1'b0; r.Write = 1'b0;
        #1;
        chk("diff_addr_clr2", r.busyA, 1'b0);
        chk("diff_addr_set6", r.busyB, 1'b1);
        chk("diff_addr_data2", r.DbgData, 8'h22);
        r.Rsv = 1'b1; r.RAddress = 3'd6;
        tick();
        r.Rsv = 1'b0;
        #1;
        chk("rsv_again6", r.busyB, 1'b1);
        r.Write = 1'b1; r.DAddress = 3'd6; r.DataInRegg = 8'h66;
        tick();
        r.Write = 1'b1; r.DAddress = 3'd7; r.DataInRegg = 8'h07;
        r.AAddress = 3'd7;
        tick();
        r.Write = 1'b0;
        #1;
        chk("wr_free7_busy", r.busyA, 1'b0);
        chk("wr_free7_data", r.dataA, 8'h07);
        chk("all_clear_any", r.anyBusy, 1'b0);

        z.Write = 1'b1; z.DAddress = 3'd0; z.DataInRegg = 8'hFF;
        z.Rsv = 1'b1; z.RAddress = 3'd0;
        z.AAddress = 3'd0; z.BAddress = 3'd0; z.DbgAddress = 3'd0;
        #1;
        chk("z_r0_nobyp_a", z.dataA, 8'h00);
        chk("z_r0_nobyp_b", z.dataB, 8'h00);
        tick();
        z.Write = 1'b0; z.Rsv = 1'b0;
        #1;
        chk("z_r0_a", z.dataA, 8'h00);
        chk("z_r0_dbg", z.DbgData, 8'h00);
        chk("z_r0_busy", z.busyA, 1'b0);
        chk("z_r0_any", z.anyBusy, 1'b0);
        z.Write = 1'b1; z.DAddress = 3'd1; z.DataInRegg = 8'h99; z.AAddress = 3'd1;
        #1;
        chk("z_r1_byp", z.dataA, 8'h99);
        tick();
        z.Write = 1'b0; z.DbgAddress = 3'd1;
        #1;
        chk("z_r1_dbg", z.DbgData, 8'h99);

        for (int i = 1; i < 8; i++) begin
            r.Write = 1'b1; r.DAddress = 3'(i); r.DataInRegg = 8'(i * 8'h11);
            r.Rsv = (i == 7); r.RAddress = 3'd4;
            tick();
        end
        r.Write = 1'b0; r.Rsv = 1'b0;
        r.DbgAddress = 3'd6; r.AAddress = 3'd4;
        #1;
        chk("fill_dbg6", r.DbgData, 8'h66);
        chk("fill_busy4", r.busyA, 1'b1);
        rst_n = 1'b0;
        for (int i = 0; i < 8; i++) begin
            r.AAddress = 3'(i); r.BAddress = 3'(7 - i); r.DbgAddress = 3'(i);
            #1;
            chk($sformatf("pulse_dbg%0d", i), r.DbgData, 8'h00);
            chk($sformatf("pulse_a%0d", i), r.dataA, 8'h00);
            chk($sformatf("pulse_busya%0d", i), r.busyA, 1'b0);
        end
        chk("pulse_any", r.anyBusy, 1'b0);
        rst_n = 1'b1;
        tick();
        r.DbgAddress = 3'd4; r.AAddress = 3'd4;
        #1;
        chk("post_pulse_dbg4", r.DbgData, 8'h00);
        chk("post_pulse_busy4", r.busyA, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/regfile_scoreboard.md
REGFILE_SCOREBOARD -- requirements
Module: regfile_scoreboard

Interface
REQ-001: Parameter SIZE, default 8, data width of every register in bits.
REQ-002: Parameter NREG, default 8, number of registers (power of two, 2..32).
REQ-003: Parameter AW, default 3, address width; SHALL equal log2(NREG).
REQ-004: Parameter ZERO_R0, default 0; when 1, register 0 reads as zero and ignores writes.
REQ-005: clk  in  1  single clock; all state updates on the rising edge.
REQ-006: rst_n  in  1  reset, asynchronous assert, active-low.
REQ-007: Write  in  1  write enable for the D port.
REQ-008: DAddress  in  AW  write address.
REQ-009: DataInRegg  in  SIZE  write data.
REQ-010: Rsv  in  1  reserve request: marks a register as pending a future write.
REQ-011: RAddress  in  AW  reserve address.
REQ-012: AAddress, BAddress  in  AW  read addresses, ports A and B.
REQ-013: dataA, dataB  out  SIZE  read data, ports A and B.
REQ-014: busyA, busyB  out  1  pending flag of the register addressed by AAddress / BAddress.
REQ-015: anyBusy  out  1  OR of all pending flags.
REQ-016: DbgAddress  in  AW  debug read address; DbgData  out  SIZE  debug read data (no bypass).

Function
REQ-017: Storage: NREG registers of SIZE bits plus NREG pending bits, all in flops.
REQ-018: Write=1 at a rising edge loads DataInRegg into register DAddress; other registers hold.
REQ-019: Reads are combinational: dataA = register[AAddress], dataB = register[BAddress].
REQ-020: Write bypass: when Write=1 and DAddress equals AAddress (BAddress), dataA (dataB) SHALL equal DataInRegg in the same cycle.
REQ-021: DbgData = register[DbgAddress], stored value only, never bypassed.
REQ-022: Rsv=1 at a rising edge sets pending[RAddress].
REQ-023: Write=1 at a rising edge clears pending[DAddress].
REQ-024: Rsv and Write in the same cycle, same address: pending ends set (reserve wins), data still written.
REQ-025: Rsv and Write in the same cycle, different addresses: both take effect.
REQ-026: Rsv on an already-pending register: pending stays set, no error.
REQ-027: Write to a non-pending register: allowed, pending stays clear.
REQ-028: busyA/busyB reflect the registered pending bits only; Write/Rsv in the current cycle do not affect them combinationally.
REQ-029: ZERO_R0=1: address 0 reads 0 on dataA, dataB and DbgData; writes and reserves to address 0 are ignored; pending[0] constant 0; bypass to address 0 disabled.
REQ-030: Address ports are exactly AW bits wide; every value selects a valid register, no wrap logic needed.

Reset
REQ-031: rst_n=0 SHALL immediately, independent of clk, clear every register to 0 and every pending bit to 0.
REQ-032: During reset: dataA, dataB, DbgData = 0 unless bypass is active; busyA, busyB, anyBusy = 0.
REQ-033: Write and Rsv sampled while rst_n=0 SHALL be ignored; first update occurs at the first rising edge with rst_n=1.
REQ-034: Reset asserted mid-operation discards all stored data and pending state; no partial write survives.

Verification
REQ-035: Reset, then read all addresses on A, B, Dbg -> all 0; busyA=busyB=anyBusy=0.
REQ-036: Write=1, DAddress=5, DataInRegg=0xA5, AAddress=5 same cycle -> dataA=0xA5 combinationally, DbgData(5)=0x00 until the edge, 0xA5 after.
REQ-037: Rsv=1 RAddress=3; next cycle AAddress=3 -> busyA=1, anyBusy=1; Write=1 DAddress=3 data 0x3C -> after the edge busyA=0, anyBusy=0, dataA=0x3C.
REQ-038: Rsv=1 RAddress=2 and Write=1 DAddress=2 data 0x77 same edge -> register 2 = 0x77, busy for address 2 = 1.
REQ-039: ZERO_R0=1 build: Write=1 DAddress=0 data 0xFF, Rsv to 0 -> dataA(0)=0 same cycle and after, busy for address 0 = 0.
REQ-040: Fill registers 1..7 with 0x11..0x77, reserve 4, pulse rst_n low between edges -> all data 0, all busy 0 immediately, before the next edge.
